uart_fifo_bridge: RTL and testbench

Buffered front-end for the simple UART's data-register interface. A TX FIFO accepts bytes from the CPU-side stream port and drains them into the UART write port, honouring the UART wait signal. An RX poller moves each received byte out of the UART's single-entry receive buffer into an RX FIFO, which the CPU reads through a stream port. The block sits between the SoC bus decode and the UART, so firmware no longer spins on the UART wait signal or loses bytes between polls.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo_bridge_if.sv | 31 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_fifo_bridge.sv | 83 ++++++++
 tb/tb_uart_fifo_bridge.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART FIFO bridge.
//   UART_NO_DATA : value the UART data register reads back when it holds no byte
//   UART_BYTE_W  : width of one UART character
//   level_w()    : width of a FIFO occupancy count for a given log2 depth
package uart_pkg;

    localparam logic [31:0] UART_NO_DATA = 32'hFFFF_FFFF;
    localparam int          UART_BYTE_W  = 8;

    // Occupancy needs one bit more than the pointers so that "full" (2**depth_log2)
    // is representable alongside "empty" (0).
    function automatic int level_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// UART data-register bus between the bridge (master) and the UART (slave).
//   uart_dat_we   : write strobe, master -> slave
//   uart_dat_di   : write data {24'b0, byte}, master -> slave
//   uart_dat_wait : UART stalling the current write, slave -> master
//   uart_dat_re   : read strobe, master -> slave
//   uart_dat_do   : read data, all-ones when no byte is held, slave -> master
interface uart_fifo_bridge_if;

    logic        uart_dat_we;
    logic [31:0] uart_dat_di;
    logic        uart_dat_wait;
    logic        uart_dat_re;
    logic [31:0] uart_dat_do;

    modport master (
        output uart_dat_we,
        output uart_dat_di,
        output uart_dat_re,
        input  uart_dat_wait,
        input  uart_dat_do
    );

    modport slave (
        input  uart_dat_we,
        input  uart_dat_di,
        input  uart_dat_re,
        output uart_dat_wait,
        output uart_dat_do
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output.
//   clk, resetn : clock, synchronous active-low reset (clears pointers and level)
//   push, din   : write request and data; ignored while full, even alongside a pop
//   pop, dout   : read request; dout is the combinational head entry
//   full, empty : occupancy flags derived from level
//   level       : number of stored entries, 0 .. 2**DEPTH_LOG2
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 din,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 dout,
    output logic                             full,
    output logic                             empty,
    output logic [level_w(DEPTH_LOG2)-1:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Level never exceeds DEPTH, so its MSB is set exactly when the FIFO is full.
    assign full    = level[DEPTH_LOG2];
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; stale contents are unreachable once
    // the pointers and level are cleared, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered front-end for the UART data register.
//   clk, resetn          : clock, synchronous active-low reset
//   tx_valid/ready/data  : CPU -> TX FIFO byte stream
//   rx_valid/ready/data  : RX FIFO -> CPU byte stream, rx_data is show-ahead
//   tx_level, rx_level   : FIFO occupancies
//   uart                 : UART data-register bus (master side)
// TX bytes drain to the UART whenever the TX FIFO is non-empty, one per cycle in
// which the UART does not assert wait. Any byte the UART holds is read and pushed
// into the RX FIFO in the same cycle, unless the RX FIFO is full.
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    input  logic [UART_BYTE_W-1:0]          tx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [UART_BYTE_W-1:0]          rx_data,
    output logic [level_w(DEPTH_LOG2)-1:0]  tx_level,
    output logic [level_w(DEPTH_LOG2)-1:0]  rx_level,
    uart_fifo_bridge_if.master              uart
);

    logic                   tx_full;
    logic                   tx_empty;
    logic                   tx_pop;
    logic [UART_BYTE_W-1:0] tx_head;
    logic                   rx_full;
    logic                   rx_empty;
    logic                   rx_push;
    logic                   byte_avail;

    // Strobes and stream flags are gated with resetn so they drop in the very
    // cycle reset is asserted, before the FIFO state has been cleared.
    assign tx_ready = !resetn || !tx_full;
    assign rx_valid = resetn && !rx_empty;

    // TX drain: the UART latches the byte in the cycle wait is low.
    assign uart.uart_dat_we = resetn && !tx_empty;
    assign uart.uart_dat_di = {{(32 - UART_BYTE_W){1'b0}}, tx_head};
    assign tx_pop           = uart.uart_dat_we && !uart.uart_dat_wait;

    // RX poll: only the all-ones pattern means "empty"; 32'h0000_00FF is a real 0xFF.
    // The UART clears its buffer on the read edge, so no double read follows.
    assign byte_avail       = (uart.uart_dat_do != UART_NO_DATA);
    assign rx_push          = resetn && byte_avail && !rx_full;
    assign uart.uart_dat_re = rx_push;

    sync_fifo #(
        .WIDTH      (UART_BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_valid && tx_ready),
        .din    (tx_data),
        .pop    (tx_pop),
        .dout   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .level  (tx_level)
    );

    sync_fifo #(
        .WIDTH      (UART_BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (rx_push),
        .din    (uart.uart_dat_do[UART_BYTE_W-1:0]),
        .pop    (rx_valid && rx_ready),
        .dout   (rx_data),
        .full   (rx_full),
        .empty  (rx_empty),
        .level  (rx_level)
    );

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge. Stimulus pushes expected TX/RX bytes
// into queues; a negedge monitor pops and compares whenever the DUT hands a byte
// to the UART (we && !wait) or to the CPU (rx_valid && rx_ready).
module tb_uart_fifo_bridge;

    localparam int DL = 4;
    localparam logic [31:0] NO_DATA = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          resetn;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    rx_data;
    logic [DL:0]   tx_level;
    logic [DL:0]   rx_level;

    uart_fifo_bridge_if u ();

    uart_fifo_bridge #(.DEPTH_LOG2(DL)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .tx_level (tx_level),
        .rx_level (rx_level),
        .uart     (u)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         re_count = 0;
    logic [7:0] exp_tx [$];
    logic [7:0] exp_rx [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge with the currently driven inputs; lands just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [7:0] e;
        if (resetn) begin
            if (u.uart_dat_re) re_count++;
            if (u.uart_dat_we && !u.uart_dat_wait) begin
                if (exp_tx.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL tx_unexpected: got %h, expected no write", u.uart_dat_di);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_byte", u.uart_dat_di, {24'b0, e});
                end
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rx_unexpected: got %h, expected no byte", rx_data);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_byte", {24'b0, rx_data}, {24'b0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

    initial begin
        resetn          = 1'b0;
        tx_valid        = 1'b0;
        tx_data         = 8'h00;
        rx_ready        = 1'b0;
        u.uart_dat_wait = 1'b0;
        u.uart_dat_do   = 32'h0000_0041;

        // ---- Reset state ----
        step(); step(); step();
        mid();
        check("rst_re",       {31'b0, u.uart_dat_re}, 32'd0);
        check("rst_we",       {31'b0, u.uart_dat_we}, 32'd0);
        check("rst_tx_ready", {31'b0, tx_ready},      32'd1);
        check("rst_rx_valid", {31'b0, rx_valid},      32'd0);
        check("rst_tx_level", 32'(tx_level),          32'd0);
        check("rst_rx_level", 32'(rx_level),          32'd0);
        step();
        resetn        = 1'b1;
        u.uart_dat_do = NO_DATA;
        mid();
        check("post_rst_tx_ready", {31'b0, tx_ready},      32'd1);
        check("post_rst_we",       {31'b0, u.uart_dat_we}, 32'd0);
        check("post_rst_re",       {31'b0, u.uart_dat_re}, 32'd0);
        step();

        // ---- TX drain with wait ----
        u.uart_dat_wait = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h55; exp_tx.push_back(8'h55);
        step();
        tx_data = 8'hAA; exp_tx.push_back(8'hAA);
        mid();
        check("tx_lat_we",    {31'b0, u.uart_dat_we}, 32'd1);
        check("tx_lat_level", 32'(tx_level),          32'd1);
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("tx_wait_di",    u.uart_dat_di,          32'h0000_0055);
            check("tx_wait_we",    {31'b0, u.uart_dat_we}, 32'd1);
            check("tx_wait_level", 32'(tx_level),          32'd2);
            step();
        end
        u.uart_dat_wait = 1'b0;
        mid();
        check("tx_drain_level2", 32'(tx_level), 32'd2);
        step();
        mid();
        check("tx_drain_di_aa",  u.uart_dat_di,  32'h0000_00AA);
        check("tx_drain_level1", 32'(tx_level),  32'd1);
        step();
        mid();
        check("tx_drain_level0", 32'(tx_level),          32'd0);
        check("tx_drain_we0",    {31'b0, u.uart_dat_we}, 32'd0);
        step();

        // ---- TX full ----
        u.uart_dat_wait = 1'b1;
        tx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tx_data = 8'(i);
            exp_tx.push_back(8'(i));
            mid();
            check("tx_fill_ready", {31'b0, tx_ready}, 32'd1);
            step();
        end
        tx_valid = 1'b0;
        mid();
        check("tx_full_ready", {31'b0, tx_ready}, 32'd0);
        check("tx_full_level", 32'(tx_level),     32'd16);
        step();
        // 17th push coincides with a pop of 0x00 and must be refused.
        tx_valid = 1'b1; tx_data = 8'h99; u.uart_dat_wait = 1'b0;
        mid();
        check("tx_full_push_ready", {31'b0, tx_ready}, 32'd0);
        step();
        tx_valid = 1'b0;
        mid();
        check("tx_refused_level", 32'(tx_level), 32'd15);
        step();
        for (int i = 0; i < 14; i++) step();
        mid();
        check("tx_full_drained_level", 32'(tx_level),          32'd0);
        check("tx_full_drained_we",    {31'b0, u.uart_dat_we}, 32'd0);
        step();

        // ---- RX poll ----
        re_count      = 0;
        u.uart_dat_do = 32'h0000_00FF;
        mid();
        check("rx_poll_re", {31'b0, u.uart_dat_re}, 32'd1);
        step();
        u.uart_dat_do = NO_DATA;
        mid();
        check("rx_poll_re_clear", {31'b0, u.uart_dat_re}, 32'd0);
        check("rx_poll_valid",    {31'b0, rx_valid},      32'd1);
        check("rx_poll_data",     {24'b0, rx_data},       32'h0000_00FF);
        check("rx_poll_level",    32'(rx_level),          32'd1);
        step();
        rx_ready = 1'b1; exp_rx.push_back(8'hFF);
        step();
        rx_ready = 1'b0;
        mid();
        check("rx_poll_re_count", 32'(re_count), 32'd1);
        check("rx_poll_level0",   32'(rx_level), 32'd0);
        step();

        // ---- RX full back-pressure ----
        for (int i = 0; i < 16; i++) begin
            u.uart_dat_do = {24'b0, 8'(8'h20 + i)};
            exp_rx.push_back(8'(8'h20 + i));
            step();
        end
        u.uart_dat_do = 32'h0000_0033;
        exp_rx.push_back(8'h33);
        re_count = 0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("rx_full_re",    {31'b0, u.uart_dat_re}, 32'd0);
            check("rx_full_level", 32'(rx_level),          32'd16);
            step();
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        mid();
        check("rx_refill_re",    {31'b0, u.uart_dat_re}, 32'd1);
        check("rx_refill_level", 32'(rx_level),          32'd15);
        step();
        u.uart_dat_do = NO_DATA;
        mid();
        check("rx_refill_level16", 32'(rx_level),          32'd16);
        check("rx_refill_re_cnt",  32'(re_count),          32'd1);
        check("rx_refill_re_idle", {31'b0, u.uart_dat_re}, 32'd0);
        step();
        rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) step();
        rx_ready = 1'b0;
        mid();
        check("rx_drained_level", 32'(rx_level),     32'd0);
        check("rx_drained_valid", {31'b0, rx_valid}, 32'd0);
        step();

        // ---- Mid-operation reset ----
        u.uart_dat_wait = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h10; u.uart_dat_do = 32'h0000_0061; step();
        tx_data = 8'h11; u.uart_dat_do = 32'h0000_0062; step();
        tx_data = 8'h12; u.uart_dat_do = NO_DATA;       step();
        tx_valid = 1'b0;
        mid();
        check("mid_pre_tx_level", 32'(tx_level), 32'd3);
        check("mid_pre_rx_level", 32'(rx_level), 32'd2);
        step();
        resetn = 1'b0;
        u.uart_dat_do = 32'h0000_0070;
        mid();
        check("mid_rst_we", {31'b0, u.uart_dat_we}, 32'd0);
        check("mid_rst_re", {31'b0, u.uart_dat_re}, 32'd0);
        step();
        resetn = 1'b1;
        u.uart_dat_do = NO_DATA;
        u.uart_dat_wait = 1'b0;
        mid();
        check("mid_rst_tx_level", 32'(tx_level), 32'd0);
        check("mid_rst_rx_level", 32'(rx_level), 32'd0);
        for (int i = 0; i < 4; i++) begin
            mid();
            check("mid_idle_we",    {31'b0, u.uart_dat_we}, 32'd0);
            check("mid_idle_re",    {31'b0, u.uart_dat_re}, 32'd0);
            check("mid_idle_rxval", {31'b0, rx_valid},      32'd0);
            step();
        end
        tx_valid = 1'b1; tx_data = 8'h5A; exp_tx.push_back(8'h5A);
        step();
        tx_valid = 1'b0;
        step(); step();

        check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        check("rx_queue_empty", 32'(exp_rx.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
